rom_port_arbiter: RTL

Sequences and shares the single cartridge ROM/SDRAM port between three requesters: the HPS loader (`IO_WR` path), the S-CPU-side mapper fetch, and a coprocessor fetch (GSU/SA-1/SPC7110 data side). It sits between the active mapper's `rom_*` outputs and the external memory controller, replacing direct `ROM_CE_N`/`ROM_OE_N` strobing with a request/acknowledge handshake. It provides fixed priority with a starvation guard, a halt gate, and a completion watchdog.

---
 rtl/rom_arb_pkg.sv | 38 +++
 rtl/rom_arb_if.sv | 62 ++++++
 rtl/rom_arb_select.sv | 28 ++
 rtl/rom_port_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the cartridge ROM port arbiter.
// Holds grant/state encodings, the timeout read value and the
// byte/word data formatting helpers used by the top level.
package rom_arb_pkg;

    // Encoding of the grant output: which requester owns the memory port.
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_LD   = 2'd1;
    localparam logic [1:0] GNT_CPU  = 2'd2;
    localparam logic [1:0] GNT_COP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Read data returned when the memory never acknowledged.
    localparam logic [15:0] RD_TIMEOUT_VAL = 16'hFFFF;

    // Byte writes replicate the low byte onto both lanes so the controller
    // can strobe either lane without needing a shifted copy.
    function automatic logic [15:0] fmt_wdata(input logic [15:0] wdata,
                                              input logic        word);
        return word ? wdata : {wdata[7:0], wdata[7:0]};
    endfunction

    // Byte reads pick the lane selected by address bit 0 and zero-extend.
    function automatic logic [15:0] fmt_rdata(input logic [15:0] q,
                                              input logic        word,
                                              input logic        a0);
        if (word) begin
            return q;
        end
        return {8'h00, a0 ? q[15:8] : q[7:0]};
    endfunction

endpackage

// File: rtl/rom_arb_if.sv
// Bundle of the three requester ports and the memory-controller port.
// slave: arbiter view (serves requests, drives memory). master: environment
// view (requesters plus memory controller model).
interface rom_arb_if #(parameter int ADDR_W = 24);

    // Loader (write-only)
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [15:0]       ld_wdata;
    logic              ld_word;
    logic              ld_ack;

    // S-CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic              cpu_word;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata;
    logic [15:0]       cpu_rdata;
    logic              cpu_ack;

    // Coprocessor side
    logic              cop_req;
    logic              cop_we;
    logic              cop_word;
    logic [ADDR_W-1:0] cop_addr;
    logic [15:0]       cop_wdata;
    logic [15:0]       cop_rdata;
    logic              cop_ack;

    // Memory controller side
    logic              mem_req;
    logic              mem_we;
    logic              mem_word;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_d;
    logic [15:0]       mem_q;
    logic              mem_ack;

    modport slave (
        input  ld_req, ld_addr, ld_wdata, ld_word,
        output ld_ack,
        input  cpu_req, cpu_we, cpu_word, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  cop_req, cop_we, cop_word, cop_addr, cop_wdata,
        output cop_rdata, cop_ack,
        output mem_req, mem_we, mem_word, mem_addr, mem_d,
        input  mem_q, mem_ack
    );

    modport master (
        output ld_req, ld_addr, ld_wdata, ld_word,
        input  ld_ack,
        output cpu_req, cpu_we, cpu_word, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output cop_req, cop_we, cop_word, cop_addr, cop_wdata,
        input  cop_rdata, cop_ack,
        input  mem_req, mem_we, mem_word, mem_addr, mem_d,
        output mem_q, mem_ack
    );

endinterface

// File: rtl/rom_arb_select.sv
// Winner selection for the ROM port: loader > cpu > cop, halt masks cpu/cop,
// starvation flag lets cop outrank cpu. Purely combinational, no latency.
// Ports: ld/cpu/cop_req (already masked), halt, starve in; win (grant code) out.
module rom_arb_select
    import rom_arb_pkg::*;
(
    input  logic       ld_req,
    input  logic       cpu_req,
    input  logic       cop_req,
    input  logic       halt,
    input  logic       starve,
    output logic [1:0] win
);

    always_comb begin
        win = GNT_NONE;
        if (ld_req) begin
            win = GNT_LD;
        end else if (!halt) begin
            if (cop_req && (starve || !cpu_req)) begin
                win = GNT_COP;
            end else if (cpu_req) begin
                win = GNT_CPU;
            end
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one cartridge ROM/SDRAM port between loader, S-CPU and coprocessor.
// Latency: req seen in IDLE at n -> mem_req at n+1; mem_ack at m -> *_ack at m+1.
// Backpressure: requesters hold req until a one-cycle ack; memory stalls via
// mem_ack, bounded by a TIMEOUT-cycle watchdog that forces completion.
// Ports: mclk/rst_n, halt; bus (requester + memory ports); grant/busy/timeout_err status.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          halt,
    rom_arb_if.slave      bus,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          timeout_err
);

    localparam int                SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [7:0]        TO_LAST    = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_word_q, mem_word_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_d_q, mem_d_d;
    logic              ld_ack_q, ld_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cop_ack_q, cop_ack_d;
    logic [15:0]       cpu_rdata_q, cpu_rdata_d;
    logic [15:0]       cop_rdata_q, cop_rdata_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [7:0]        to_cnt_q, to_cnt_d;

    logic       in_done;
    logic [1:0] win;
    logic [15:0] rd_dat;
    logic       finish;

    // The owner of the transaction completing in DONE must not be re-granted
    // off the same request level; its req is hidden for that cycle.
    assign in_done = (state_q == ST_DONE);

    rom_arb_select u_select (
        .ld_req  (bus.ld_req  && !(in_done && grant_q == GNT_LD)),
        .cpu_req (bus.cpu_req && !(in_done && grant_q == GNT_CPU)),
        .cop_req (bus.cop_req && !(in_done && grant_q == GNT_COP)),
        .halt    (halt),
        .starve  (starve_cnt_q >= STARVE_LIM),
        .win     (win)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        timeout_err_d = timeout_err_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_word_d    = mem_word_q;
        mem_addr_d    = mem_addr_q;
        mem_d_d       = mem_d_q;
        ld_ack_d      = 1'b0;
        cpu_ack_d     = 1'b0;
        cop_ack_d     = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        cop_rdata_d   = cop_rdata_q;
        starve_cnt_d  = starve_cnt_q;
        to_cnt_d      = to_cnt_q;
        rd_dat        = RD_TIMEOUT_VAL;
        finish        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win != GNT_NONE) begin
                    state_d   = ST_ISSUE;
                    grant_d   = win;
                    mem_req_d = 1'b1;
                    to_cnt_d  = 8'd0;
                    case (win)
                        GNT_LD: begin
                            mem_we_d   = 1'b1;
                            mem_word_d = bus.ld_word;
                            mem_addr_d = bus.ld_addr;
                            mem_d_d    = fmt_wdata(bus.ld_wdata, bus.ld_word);
                        end
                        GNT_CPU: begin
                            mem_we_d   = bus.cpu_we;
                            mem_word_d = bus.cpu_word;
                            mem_addr_d = bus.cpu_addr;
                            mem_d_d    = fmt_wdata(bus.cpu_wdata, bus.cpu_word);
                            if (bus.cop_req && starve_cnt_q < STARVE_LIM) begin
                                starve_cnt_d = starve_cnt_q + SW'(1);
                            end
                        end
                        default: begin
                            mem_we_d     = bus.cop_we;
                            mem_word_d   = bus.cop_word;
                            mem_addr_d   = bus.cop_addr;
                            mem_d_d      = fmt_wdata(bus.cop_wdata, bus.cop_word);
                            starve_cnt_d = '0;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                // A real ack beats an expiring watchdog in the same cycle.
                if (bus.mem_ack) begin
                    rd_dat = fmt_rdata(bus.mem_q, mem_word_q, mem_addr_q[0]);
                    finish = 1'b1;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    finish        = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
                if (finish) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    case (grant_q)
                        GNT_LD:  ld_ack_d = 1'b1;
                        GNT_CPU: begin
                            cpu_ack_d   = 1'b1;
                            cpu_rdata_d = rd_dat;
                        end
                        GNT_COP: begin
                            cop_ack_d   = 1'b1;
                            cop_rdata_d = rd_dat;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = GNT_NONE;
            end
            default: begin
                state_d   = ST_IDLE;
                grant_d   = GNT_NONE;
                mem_req_d = 1'b0;
            end
        endcase

        // Starvation only matters while cop is actually waiting.
        if (!bus.cop_req) begin
            starve_cnt_d = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= GNT_NONE;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_word_q    <= 1'b0;
            mem_addr_q    <= '0;
            mem_d_q       <= 16'h0000;
            ld_ack_q      <= 1'b0;
            cpu_ack_q     <= 1'b0;
            cop_ack_q     <= 1'b0;
            cpu_rdata_q   <= 16'h0000;
            cop_rdata_q   <= 16'h0000;
            starve_cnt_q  <= '0;
            to_cnt_q      <= 8'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_word_q    <= mem_word_d;
            mem_addr_q    <= mem_addr_d;
            mem_d_q       <= mem_d_d;
            ld_ack_q      <= ld_ack_d;
            cpu_ack_q     <= cpu_ack_d;
            cop_ack_q     <= cop_ack_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cop_rdata_q   <= cop_rdata_d;
            starve_cnt_q  <= starve_cnt_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_word  = mem_word_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_d     = mem_d_q;
    assign bus.ld_ack    = ld_ack_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cop_ack   = cop_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cop_rdata = cop_rdata_q;

endmodule
